walking_one_rr_arbiter: RTL and testbench

//  Round-robin arbiter for NUM_REQ requesters sharing one datapath (e.g. memory/bus port).

---
 rtl/walking_one_rr_arbiter_pkg.sv | 16 +
 rtl/walking_one_rr_arbiter_picker.sv | 44 ++++
 rtl/walking_one_rr_arbiter.sv | 114 +++++++++++
 tb/tb_walking_one_rr_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/walking_one_rr_arbiter_pkg.sv
// Shared definitions for the walking-one round-robin arbiter.
// State encoding, default watchdog limit and an index-width helper.
package walking_one_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_HOLD = 255;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/walking_one_rr_arbiter_picker.sv
// Combinational round-robin picker: rotate by pointer, find first one,
// rotate back. Emits one-hot winner, its index and an any-valid flag.
module rr_first_one_picker
    import walking_one_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [IW-1:0]        pidx;
    int                   pos;

    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        pidx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = int'(ptr_i) + i;
                if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                pidx        = IW'(pos);
                gnt_o[pidx] = 1'b1;
                idx_o       = pidx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/walking_one_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held per transaction,
// zero-bubble handover and a watchdog that forces release of a stuck owner.
module walking_one_rr_arbiter
    import walking_one_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] iRequest,
    input  logic [NUM_REQ-1:0] iRelease,
    output logic [NUM_REQ-1:0] oGrant,
    output logic               oGrantValid,
    output logic               oTimeout
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q;
    logic               timeout_q, timeout_d;

    logic               rel_ev, drop_ev, wd_ev, end_ev;
    logic [IW-1:0]      next_ptr, pick_ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    assign rel_ev   = |(iRelease & grant_q);
    assign drop_ev  = ~|(iRequest & grant_q);
    assign wd_ev    = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign end_ev   = rel_ev | drop_ev | wd_ev;
    assign next_ptr = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
    // On handover the winner is picked with the already-advanced pointer
    assign pick_ptr = (state_q == ST_OWNED) ? next_ptr : ptr_q;

    rr_first_one_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req_i(iRequest),
        .ptr_i(pick_ptr),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                grant_d = pick_gnt;
                if (pick_any) begin
                    state_d = ST_OWNED;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            (state_q == ST_OWNED): begin
                if (end_ev) begin
                    ptr_d     = next_ptr;
                    cnt_d     = '0;
                    grant_d   = pick_gnt;
                    owner_d   = pick_idx;
                    timeout_d = wd_ev & ~rel_ev & ~drop_ev;
                    state_d   = pick_any ? ST_OWNED : ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= |grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign oGrant      = grant_q;
    assign oGrantValid = valid_q;
    assign oTimeout    = timeout_q;

endmodule

// File: tb/tb_walking_one_rr_arbiter.sv
// Directed bench for walking_one_rr_arbiter (NUM_REQ=3, MAX_HOLD=8 and 0).
// Vector table for the main sequence plus hand-written multi-cycle cases.
module tb_walking_one_rr_arbiter;

    logic       Clock;
    logic       Reset_n;
    logic [2:0] req;
    logic [2:0] rel;
    logic [2:0] gnt, gnt0;
    logic       vld, vld0;
    logic       tmo, tmo0;

    int tests = 0;
    int fails = 0;

    walking_one_rr_arbiter #(.NUM_REQ(3), .MAX_HOLD(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .iRequest(req), .iRelease(rel),
        .oGrant(gnt), .oGrantValid(vld), .oTimeout(tmo)
    );

    walking_one_rr_arbiter #(.NUM_REQ(3), .MAX_HOLD(0)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n),
        .iRequest(req), .iRelease(rel),
        .oGrant(gnt0), .oGrantValid(vld0), .oTimeout(tmo0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] rel;
        logic [2:0] gnt;
        logic       tmo;
    } vec_t;

    vec_t tbl [0:20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        req = '0;
        rel = '0;
        Reset_n = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_g;
        logic       exp_t;
        logic [2:0] pat;
        int         waitc [3];
        int         worst;

        req = '0;
        rel = '0;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_grant", gnt, 3'b000);
        chk("rst_valid", vld, 1'b0);
        chk("rst_tmo", tmo, 1'b0);

        // Async reset mid-grant clears outputs without a clock edge
        step();
        Reset_n = 1'b1;
        req = 3'b010;
        step();
        chk("pre_rst_grant", gnt, 3'b010);
        chk("pre_rst_valid", vld, 1'b1);
        #3 Reset_n = 1'b0;
        #1;
        chk("async_rst_grant", gnt, 3'b000);
        chk("async_rst_valid", vld, 1'b0);
        step();
        Reset_n = 1'b1;
        step();
        chk("post_rst_grant", gnt, 3'b010);

        tbl[0]  = '{3'b111, 3'b000, 3'b001, 1'b0};
        tbl[1]  = '{3'b111, 3'b000, 3'b001, 1'b0};
        tbl[2]  = '{3'b111, 3'b001, 3'b010, 1'b0};
        tbl[3]  = '{3'b111, 3'b000, 3'b010, 1'b0};
        tbl[4]  = '{3'b111, 3'b010, 3'b100, 1'b0};
        tbl[5]  = '{3'b111, 3'b000, 3'b100, 1'b0};
        tbl[6]  = '{3'b111, 3'b100, 3'b001, 1'b0};
        tbl[7]  = '{3'b111, 3'b000, 3'b001, 1'b0};
        tbl[8]  = '{3'b110, 3'b000, 3'b010, 1'b0};
        tbl[9]  = '{3'b110, 3'b101, 3'b010, 1'b0};
        tbl[10] = '{3'b010, 3'b101, 3'b010, 1'b0};
        tbl[11] = '{3'b110, 3'b010, 3'b100, 1'b0};
        tbl[12] = '{3'b100, 3'b100, 3'b100, 1'b0};
        tbl[13] = '{3'b000, 3'b000, 3'b000, 1'b0};
        tbl[14] = '{3'b000, 3'b010, 3'b000, 1'b0};
        tbl[15] = '{3'b011, 3'b000, 3'b001, 1'b0};
        tbl[16] = '{3'b000, 3'b000, 3'b000, 1'b0};
        tbl[17] = '{3'b011, 3'b000, 3'b010, 1'b0};
        tbl[18] = '{3'b000, 3'b000, 3'b000, 1'b0};
        tbl[19] = '{3'b011, 3'b000, 3'b001, 1'b0};
        tbl[20] = '{3'b000, 3'b000, 3'b000, 1'b0};

        apply_reset();
        for (int i = 0; i < 21; i++) begin
            req = tbl[i].req;
            rel = tbl[i].rel;
            step();
            chk($sformatf("vec%0d_grant", i), gnt, tbl[i].gnt);
            chk($sformatf("vec%0d_valid", i), vld, |tbl[i].gnt);
            chk($sformatf("vec%0d_tmo", i), tmo, tbl[i].tmo);
            chk($sformatf("vec%0d_grant_nowd", i), gnt0, tbl[i].gnt);
        end

        // Watchdog: 101 held with no releases
        apply_reset();
        req = 3'b101;
        rel = 3'b000;
        for (int s = 1; s <= 20; s++) begin
            step();
            exp_g = (s <= 8) ? 3'b001 : (s <= 16) ? 3'b100 : 3'b001;
            exp_t = (s == 9) || (s == 17);
            chk($sformatf("wd%0d_grant", s), gnt, exp_g);
            chk($sformatf("wd%0d_tmo", s), tmo, exp_t);
            chk($sformatf("wd%0d_grant_nowd", s), gnt0, 3'b001);
            chk($sformatf("wd%0d_tmo_nowd", s), tmo0, 1'b0);
        end

        // Sole requester: release with request held restarts the counter
        apply_reset();
        req = 3'b100;
        for (int s = 1; s <= 22; s++) begin
            rel = (s == 6 || s == 22) ? 3'b100 : 3'b000;
            step();
            chk($sformatf("sole%0d_grant", s), gnt, 3'b100);
            chk($sformatf("sole%0d_tmo", s), tmo, (s == 14) ? 1'b1 : 1'b0);
        end
        rel = 3'b000;

        // Stress: zero/one-hot grant and bounded wait per steady requester
        apply_reset();
        for (int p = 0; p < 8; p++) begin
            pat = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) waitc[k] = 0;
            for (int c = 0; c < 40; c++) begin
                req = pat;
                rel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
                step();
                chk($sformatf("stress%0d_%0d_onehot", p, c), $onehot0(gnt), 1'b1);
                worst = 0;
                for (int k = 0; k < 3; k++) begin
                    if (req[k] && !gnt[k]) waitc[k]++;
                    else waitc[k] = 0;
                    if (waitc[k] > worst) worst = waitc[k];
                end
                chk($sformatf("stress%0d_%0d_starve", p, c), (worst <= 16), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
